// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor sequencer.
//   state_t        : sequencer FSM states (IDLE/LOAD/SHIFT/DONE)
//   DEFAULT_WIDTH  : default operand/result width
//   cnt_width()    : bit-counter width for a given operand width
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    function automatic int cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/sub_flag_unit.sv
// Z/N/V flag computation for an X-Y subtraction result.
// Ports:
//   x, y : operands (WIDTH)
//   d    : difference X-Y mod 2^WIDTH (WIDTH)
//   z    : d is zero
//   n    : d MSB
//   v    : signed overflow
module sub_flag_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] d,
    output logic             z,
    output logic             n,
    output logic             v
);

    always_comb begin
        z = (d == '0);
        n = d[WIDTH-1];
        // Overflow only when operand signs differ and the result sign
        // disagrees with the minuend.
        v = (x[WIDTH-1] ^ y[WIDTH-1]) & (d[WIDTH-1] ^ x[WIDTH-1]);
    end

endmodule

// File: rtl/serial_sub_sequencer.sv
// Control-and-collect stage for the bit-serial subtractor datapath.
// Accepts an operand pair, loads the datapath, steps it WIDTH times LSB
// first, collects the serial difference and presents the result.
// Optional feature macro: SUB_SEQ_FLAGS_EN (registered Z/N/V flags;
// when undefined the flags are tied to 0).
// Ports:
//   CLK, R                       : clock, synchronous active-high reset
//   in_valid/in_ready            : operand handshake
//   minuend, subtrahend          : X / Y operands
//   ld, ld_x, ld_y               : datapath load strobe and latched operands
//   borrow_clr, shift_en         : datapath borrow clear / step strobes
//   diff_bit, borrow_bit         : datapath serial outputs
//   res_valid/res_ready          : result handshake
//   difference, borrow           : X-Y result and final borrow
//   flag_z, flag_n, flag_v       : zero / negative / signed-overflow flags
//   busy                         : not IDLE
module serial_sub_sequencer
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             ld,
    output logic [WIDTH-1:0] ld_x,
    output logic [WIDTH-1:0] ld_y,
    output logic             borrow_clr,
    output logic             shift_en,
    input  logic             diff_bit,
    input  logic             borrow_bit,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] diff_nx;
    logic            last_shift;

    assign diff_nx    = {diff_bit, difference[WIDTH-1:1]};
    assign last_shift = (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge CLK) begin
        if (R) begin
            state      <= IDLE;
            cnt        <= '0;
            ld_x       <= '0;
            ld_y       <= '0;
            difference <= '0;
            borrow     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ld_x <= minuend;
                        ld_y <= subtrahend;
                    end
                end
                LOAD: cnt <= '0;
                SHIFT: begin
                    difference <= diff_nx;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        borrow <= borrow_bit;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_SEQ_FLAGS_EN
    logic z_nx, n_nx, v_nx;

    // Flags are evaluated on the final shift using the about-to-be
    // registered difference, so they settle together with it.
    sub_flag_unit #(.WIDTH(WIDTH)) u_flags (
        .x (ld_x),
        .y (ld_y),
        .d (diff_nx),
        .z (z_nx),
        .n (n_nx),
        .v (v_nx)
    );

    always_ff @(posedge CLK) begin
        if (R) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else if (last_shift) begin
            flag_z <= z_nx;
            flag_n <= n_nx;
            flag_v <= v_nx;
        end
    end
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
    assign flag_v = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        ld         = 1'b0;
        borrow_clr = 1'b0;
        shift_en   = 1'b0;
        res_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = LOAD;
            end
            LOAD: begin
                ld         = 1'b1;
                borrow_clr = 1'b1;
                state_nx   = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_shift) state_nx = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Self-checking bench for serial_sub_sequencer (WIDTH=8) with a
// behavioural model of the bit-serial subtractor datapath.
// Flag expectations follow SUB_SEQ_FLAGS_EN (flags read 0 when undefined).
module tb_serial_sub_sequencer;

    localparam int unsigned W = 8;
`ifdef SUB_SEQ_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    logic         CLK, R;
    logic         in_valid, in_ready;
    logic [W-1:0] minuend, subtrahend;
    logic         ld, borrow_clr, shift_en;
    logic [W-1:0] ld_x, ld_y;
    logic         diff_bit, borrow_bit;
    logic         res_valid, res_ready;
    logic [W-1:0] difference;
    logic         borrow, flag_z, flag_n, flag_v, busy;

    int total = 0;
    int bad   = 0;

    serial_sub_sequencer #(.WIDTH(W)) dut (
        .CLK(CLK), .R(R),
        .in_valid(in_valid), .in_ready(in_ready),
        .minuend(minuend), .subtrahend(subtrahend),
        .ld(ld), .ld_x(ld_x), .ld_y(ld_y),
        .borrow_clr(borrow_clr), .shift_en(shift_en),
        .diff_bit(diff_bit), .borrow_bit(borrow_bit),
        .res_valid(res_valid), .res_ready(res_ready),
        .difference(difference), .borrow(borrow),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural serial datapath: two shift registers and a borrow FF.
    logic [W-1:0] m_x, m_y;
    logic         m_b;
    assign diff_bit   = m_x[0] ^ m_y[0] ^ m_b;
    assign borrow_bit = (~m_x[0] & m_y[0]) | (~(m_x[0] ^ m_y[0]) & m_b);
    always @(posedge CLK) begin
        if (ld) begin
            m_x <= ld_x;
            m_y <= ld_y;
        end
        if (borrow_clr) m_b <= 1'b0;
        if (shift_en) begin
            m_x <= m_x >> 1;
            m_y <= m_y >> 1;
            m_b <= borrow_bit;
        end
    end

    typedef struct {
        logic [W-1:0] x, y, d;
        logic         b, z, n, v;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offers one operand pair and runs until res_valid (bounded); leaves
    // the DUT in DONE. lat counts edges from the acceptance edge inclusive.
    task automatic offer(input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int shifts, output int lds,
                         output bit excl);
        @(negedge CLK);
        chk("in_ready_before_offer", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; minuend = x; subtrahend = y;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        lat = 1; shifts = 0; lds = 0; excl = 1'b1;
        while (!res_valid && lat < 40) begin
            if (shift_en) shifts++;
            if (ld) lds++;
            if (shift_en && (ld || borrow_clr)) excl = 1'b0;
            if (in_ready || !busy) excl = 1'b0;
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic check_result(input vec_t e);
        chk("res_valid", {31'b0, res_valid}, 32'd1);
        chk("difference", {24'b0, difference}, {24'b0, e.d});
        chk("borrow", {31'b0, borrow}, {31'b0, e.b});
        chk("flags_znv", {29'b0, flag_z, flag_n, flag_v},
            {29'b0, e.z & FL, e.n & FL, e.v & FL});
        chk("in_ready_done", {31'b0, in_ready}, 32'd0);
    endtask

    task automatic release_result();
        @(negedge CLK);
        res_ready = 1'b1;
        @(posedge CLK); #1;
        res_ready = 1'b0;
        chk("res_valid_after_accept", {31'b0, res_valid}, 32'd0);
        chk("in_ready_after_accept", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t e);
        int lat, shifts, lds;
        bit excl;
        offer(e.x, e.y, lat, shifts, lds, excl);
        chk("latency", lat, 32'd10);
        chk("shift_count", shifts, W);
        chk("ld_count", lds, 32'd1);
        chk("strobe_exclusive", {31'b0, excl}, 32'd1);
        check_result(e);
    endtask

    initial begin
        int lat, shifts, lds;
        bit excl;
        vec_t e;

        //          x      y      d     b     z     n     v
        vecs[0] = '{8'h34, 8'hF7, 8'h3D, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h55, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};

        R = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        minuend = '0; subtrahend = '0;
        repeat (3) @(posedge CLK);
        #1 R = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_strobes", {29'b0, ld, borrow_clr, shift_en}, 32'd0);
        chk("rst_regs", {8'b0, difference, ld_x, ld_y}, 32'd0);
        chk("rst_borrow_flags", {28'b0, borrow, flag_z, flag_n, flag_v}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            release_result();
        end

        // Consumer stall: outputs frozen while res_ready is low.
        offer(8'h34, 8'hF7, lat, shifts, lds, excl);
        chk("stall_latency", lat, 32'd10);
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            check_result(vecs[0]);
            chk("stall_shift_en", {31'b0, shift_en}, 32'd0);
        end
        release_result();

        // Reset during the 4th SHIFT cycle discards the operation.
        @(negedge CLK);
        in_valid = 1'b1; minuend = 8'hAA; subtrahend = 8'h11;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("mid_shift_en", {31'b0, shift_en}, 32'd1);
        R = 1'b1;
        @(posedge CLK); #1;
        R = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("midrst_shift_en", {31'b0, shift_en}, 32'd0);
        chk("midrst_regs", {8'b0, difference, ld_x, ld_y}, 32'd0);
        chk("midrst_borrow", {31'b0, borrow}, 32'd0);
        e = vecs[6];
        run_vec(e);
        release_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_sub_sequencer.md
# serial_sub_sequencer

Control-and-collect stage for the bit-serial subtractor datapath. Accepts an operand pair over a valid/ready handshake and loads it into the minuend/subtrahend shift registers. Clears the borrow flip-flop, then steps the datapath for WIDTH shift cycles. Collects the serial difference bits into a parallel result and presents the result, final borrow and Z/N/V flags over a second valid/ready handshake. It sits between the operand source and the serial datapath (upstream driver) and also consumes the datapath's serial output (downstream collector).

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2–32.
- CLK  in  1  clock; all state changes on rising edge.
- R  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  sequencer can accept an operand pair.
- minuend  in  WIDTH  X operand; sampled when in_valid & in_ready.
- subtrahend  in  WIDTH  Y operand; sampled when in_valid & in_ready.
- ld  out  1  load strobe to both datapath shift registers.
- ld_x  out  WIDTH  latched X, driven to the datapath load port.
- ld_y  out  WIDTH  latched Y, driven to the datapath load port.
- borrow_clr  out  1  clears the datapath borrow flip-flop.
- shift_en  out  1  advances the datapath one bit, LSB first.
- diff_bit  in  1  datapath difference bit for the current bit index; combinational, valid while shift_en=1.
- borrow_bit  in  1  datapath borrow-out for the current bit index; valid while shift_en=1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- difference  out  WIDTH  X−Y mod 2^WIDTH.
- borrow  out  1  final borrow (1 when X<Y unsigned).
- flag_z / flag_n / flag_v  out  1 each  zero, negative (difference MSB), signed overflow.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch minuend/subtrahend into ld_x/ld_y, go to LOAD.
- LOAD (exactly 1 cycle):
  - ld=1 and borrow_clr=1.
  - Bit counter cleared to 0.
  - Go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - shift_en=1.
  - Each cycle: result <= {diff_bit, result[WIDTH-1:1]}, then counter++.
  - When counter==WIDTH-1: capture borrow_bit into borrow, compute flags, go to DONE.
- DONE:
  - res_valid=1; difference, borrow and flags held stable.
  - On res_ready: go to IDLE.
  - in_ready=0 throughout; DONE never accepts a new operand pair.
- Flag arithmetic, using latched X/Y and final D:
  - Z = (D==0).
  - N = D[WIDTH-1].
  - V = (X[MSB]^Y[MSB]) & (D[MSB]^X[MSB]).
- Datapath strobes:
  - ld, borrow_clr and shift_en are mutually exclusive.
  - All three are 0 in IDLE and DONE.
- Reset (any state, including mid-SHIFT):
  - Next state IDLE; counter 0; result, borrow and flags cleared to 0.
  - res_valid=0, ld=0, shift_en=0, borrow_clr=0, busy=0.
  - ld_x/ld_y cleared to 0.
  - Any in-flight operation is discarded with no result.
- In the first cycle after reset release, in_ready=1.

## Timing
- Acceptance on rising edge t0.
- LOAD in cycle t0+1.
- SHIFT in cycles t0+2 … t0+WIDTH+1.
- res_valid first high in cycle t0+WIDTH+2 (10 cycles for WIDTH=8).
- Result handshake completes on the edge where res_valid & res_ready.
- in_ready returns high the following cycle.
- Minimum initiation interval: WIDTH+4 cycles.
- res_ready held low: all outputs frozen indefinitely.
- in_valid while busy: ignored; the operand source must hold it.

## Configuration
- SUB_SEQ_FLAGS_EN defined:
  - flag_z, flag_n and flag_v are computed and registered as above.
- SUB_SEQ_FLAGS_EN undefined:
  - flag_z, flag_n and flag_v are tied to 0 and the flag logic is absent.
  - difference, borrow and handshakes are unchanged.

## Structure
- Shared package serial_sub_pkg:
  - state enum (IDLE/LOAD/SHIFT/DONE);
  - default WIDTH constant;
  - counter width $clog2(WIDTH).
- One sub-module, sub_flag_unit:
  - inputs X, Y, D; outputs Z/N/V;
  - instantiated only under SUB_SEQ_FLAGS_EN.

## Test plan
The bench models the serial datapath behaviourally, responding to ld, borrow_clr and shift_en.
- 0x34−0xF7 -> difference 0x3D, borrow=1, Z=0 N=0 V=0; res_valid exactly 10 cycles after acceptance.
- 0x55−0x55 -> 0x00, borrow=0, Z=1 N=0 V=0.
- 0x80−0x01 -> 0x7F, borrow=0, Z=0 N=0 V=1; 0x7F−0xFF -> 0x80, borrow=1, N=1 V=1.
- res_ready held low 5 cycles after res_valid -> difference and flags stable, in_ready=0, shift_en=0; releases on the 6th cycle.
- R asserted during the 4th SHIFT cycle -> next cycle IDLE, res_valid=0, in_ready=1; the following 0x10−0x01 yields 0x0F.
- Build without SUB_SEQ_FLAGS_EN, run 0x55−0x55 -> difference 0x00, all flags 0.
